// File: rtl/writeback_unit.sv
// Register-file writeback stage: delays the writeback sideband to line up with the ALU result, then extends loads and registers one RF write.
// Latency: i_valid at cycle t gives o_rf_* at t+ALU_LATENCY+1. o_instret counts that instruction in the same cycle.
// Backpressure: none. One instruction is accepted every cycle, and the stage never stalls.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   i_valid/i_tid/i_rd/i_wb_sel      issue-time sideband: thread, destination, and source select (00 ALU, 01 load, 10 PC+4, 11 none)
//   i_pc_plus4                       link value for JAL/JALR
//   i_load_funct3/i_load_addr_lo     load format and byte offset within the word
//   i_alu_result/i_load_rdata        data arriving ALU_LATENCY cycles after issue
//   i_instret_clr                    synchronous clear of the retire counter (wins over an increment)
//   o_rf_we/o_rf_tid/o_rf_waddr/o_rf_wdata   registered register-file write port
//   o_misaligned                     one-cycle pulse when a misaligned load has its write suppressed
//   o_instret                        64-bit retired-instruction counter
module writeback_unit #(
    parameter int DWIDTH      = 32,
    parameter int NUM_THREADS = 16,
    parameter int TID_WIDTH   = $clog2(NUM_THREADS),
    parameter int ALU_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [TID_WIDTH-1:0] i_tid,
    input  logic [4:0]           i_rd,
    input  logic [1:0]           i_wb_sel,
    input  logic [DWIDTH-1:0]    i_pc_plus4,
    input  logic [2:0]           i_load_funct3,
    input  logic [1:0]           i_load_addr_lo,
    input  logic [DWIDTH-1:0]    i_alu_result,
    input  logic [DWIDTH-1:0]    i_load_rdata,
    input  logic                 i_instret_clr,
    output logic                 o_rf_we,
    output logic [TID_WIDTH-1:0] o_rf_tid,
    output logic [4:0]           o_rf_waddr,
    output logic [DWIDTH-1:0]    o_rf_wdata,
    output logic                 o_misaligned,
    output logic [63:0]          o_instret
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [TID_WIDTH-1:0] tid;
        logic [4:0]           rd;
        logic [1:0]           wb_sel;
        logic [DWIDTH-1:0]    pc_plus4;
        logic [2:0]           funct3;
        logic [1:0]           addr_lo;
    } sb_t;

    sb_t sb_in;
    sb_t sb_al;   // sideband aligned with i_alu_result / i_load_rdata

    assign sb_in = {i_valid, i_tid, i_rd, i_wb_sel, i_pc_plus4, i_load_funct3, i_load_addr_lo};

    // Delay line matching the ALU pipe depth. At depth 0 the sideband is used as it arrives.
    generate
        if (ALU_LATENCY == 0) begin : g_nodelay
            assign sb_al = sb_in;
        end else begin : g_delay
            sb_t pipe_q [ALU_LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < ALU_LATENCY; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else begin
                    pipe_q[0] <= sb_in;
                    for (int k = 1; k < ALU_LATENCY; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign sb_al = pipe_q[ALU_LATENCY-1];
        end
    endgenerate

    // Load extension: shift the addressed byte or halfword down to bit 0 first.
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] load_ext;

    assign shifted = i_load_rdata >> {sb_al.addr_lo, 3'b000};

    always_comb begin
        load_ext = i_load_rdata;
        case (sb_al.funct3)
            3'b000:  load_ext = {{(DWIDTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_ext = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(DWIDTH-8){1'b0}},         shifted[7:0]};
            3'b101:  load_ext = {{(DWIDTH-16){1'b0}},        shifted[15:0]};
            default: load_ext = i_load_rdata;   // LW and the reserved encodings
        endcase
    end

    // Misalignment: a halfword may not cross the word, and a word must start at offset 0.
    logic fmt_misaligned;
    logic mis_nxt;

    always_comb begin
        fmt_misaligned = 1'b0;
        case (sb_al.funct3)
            3'b001, 3'b101:                 fmt_misaligned = (sb_al.addr_lo == 2'd3);
            3'b010, 3'b011, 3'b110, 3'b111: fmt_misaligned = (sb_al.addr_lo != 2'd0);
            default:                        fmt_misaligned = 1'b0;
        endcase
    end

    assign mis_nxt = sb_al.valid & (sb_al.wb_sel == WB_LOAD) & fmt_misaligned;

    logic [DWIDTH-1:0] wdata_nxt;
    logic              we_nxt;

    always_comb begin
        wdata_nxt = '0;   // no-write slots present zero data
        case (sb_al.wb_sel)
            WB_ALU:  wdata_nxt = i_alu_result;
            WB_LOAD: wdata_nxt = load_ext;
            WB_PC4:  wdata_nxt = sb_al.pc_plus4;
            default: wdata_nxt = '0;
        endcase
    end

    // x0 writes are dropped, but their data is still driven.
    assign we_nxt = sb_al.valid & (sb_al.wb_sel != 2'b11) & (sb_al.rd != 5'd0) & ~mis_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rf_we      <= 1'b0;
            o_rf_tid     <= '0;
            o_rf_waddr   <= '0;
            o_rf_wdata   <= '0;
            o_misaligned <= 1'b0;
            o_instret    <= '0;
        end else begin
            o_rf_we      <= we_nxt;
            o_misaligned <= mis_nxt;
            o_rf_tid     <= sb_al.tid;
            o_rf_waddr   <= sb_al.rd;
            o_rf_wdata   <= wdata_nxt;
            // Every valid instruction retires here, including suppressed writes.
            if (i_instret_clr) begin
                o_instret <= '0;
            end else if (sb_al.valid) begin
                o_instret <= o_instret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid = 1'b0;
    logic [3:0]  i_tid = '0;
    logic [4:0]  i_rd = '0;
    logic [1:0]  i_wb_sel = '0;
    logic [31:0] i_pc_plus4 = '0;
    logic [2:0]  i_load_funct3 = '0;
    logic [1:0]  i_load_addr_lo = '0;
    logic        i_instret_clr = 1'b0;

    // Index 0/1/2 are the instances with ALU_LATENCY 0/1/3.
    logic [31:0] alu_d  [3];
    logic [31:0] rdat_d [3];
    logic        we_o   [3];
    logic [3:0]  tid_o  [3];
    logic [4:0]  wa_o   [3];
    logic [31:0] wd_o   [3];
    logic        mis_o  [3];
    logic [63:0] cnt_o  [3];

    writeback_unit #(.ALU_LATENCY(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_tid(i_tid), .i_rd(i_rd),
        .i_wb_sel(i_wb_sel), .i_pc_plus4(i_pc_plus4), .i_load_funct3(i_load_funct3),
        .i_load_addr_lo(i_load_addr_lo), .i_alu_result(alu_d[0]), .i_load_rdata(rdat_d[0]),
        .i_instret_clr(i_instret_clr), .o_rf_we(we_o[0]), .o_rf_tid(tid_o[0]),
        .o_rf_waddr(wa_o[0]), .o_rf_wdata(wd_o[0]), .o_misaligned(mis_o[0]), .o_instret(cnt_o[0]));

    writeback_unit #(.ALU_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_tid(i_tid), .i_rd(i_rd),
        .i_wb_sel(i_wb_sel), .i_pc_plus4(i_pc_plus4), .i_load_funct3(i_load_funct3),
        .i_load_addr_lo(i_load_addr_lo), .i_alu_result(alu_d[1]), .i_load_rdata(rdat_d[1]),
        .i_instret_clr(i_instret_clr), .o_rf_we(we_o[1]), .o_rf_tid(tid_o[1]),
        .o_rf_waddr(wa_o[1]), .o_rf_wdata(wd_o[1]), .o_misaligned(mis_o[1]), .o_instret(cnt_o[1]));

    writeback_unit #(.ALU_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_tid(i_tid), .i_rd(i_rd),
        .i_wb_sel(i_wb_sel), .i_pc_plus4(i_pc_plus4), .i_load_funct3(i_load_funct3),
        .i_load_addr_lo(i_load_addr_lo), .i_alu_result(alu_d[2]), .i_load_rdata(rdat_d[2]),
        .i_instret_clr(i_instret_clr), .o_rf_we(we_o[2]), .o_rf_tid(tid_o[2]),
        .o_rf_waddr(wa_o[2]), .o_rf_wdata(wd_o[2]), .o_misaligned(mis_o[2]), .o_instret(cnt_o[2]));

    typedef struct packed {
        bit        valid;
        bit [3:0]  tid;
        bit [4:0]  rd;
        bit [1:0]  wb;
        bit [31:0] pc4;
        bit [2:0]  f3;
        bit [1:0]  alo;
        bit [31:0] alu;
        bit [31:0] rdata;
        bit        clr;
        bit        has_exp;   // expectation taken from the vector table, not the model
        bit        ewe;
        bit [31:0] ewd;
        bit        emis;
    } txn_t;

    typedef struct packed {
        bit [1:0]  wb;
        bit [2:0]  f3;
        bit [1:0]  alo;
        bit [4:0]  rd;
        bit [31:0] rdata;
        bit [31:0] alu;
        bit        ewe;
        bit [31:0] ewd;
        bit        emis;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    txn_t        hist [0:4095];
    int          cyc = 0;
    int          base = 0;
    logic [63:0] exp_cnt [3];

    function automatic int lat(int k);
        return (k == 2) ? 3 : k;
    endfunction

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (latency %0d) cycle %0d: got %0h, expected %0h", name, lat(k), cyc, act, exp);
        end
    endtask

    function automatic txn_t get(int idx);
        txn_t b;
        b = '0;
        if (idx < 0 || idx < base) return b;
        return hist[idx];
    endfunction

    // Behavioural model: access size decides misalignment, and extension is done with plain masks.
    function automatic void model(txn_t t, output bit we, output bit [31:0] wd, output bit mis);
        bit [31:0] sh;
        bit [31:0] ext;
        int        size;
        sh = t.rdata >> (8 * t.alo);
        case (t.f3)
            3'd0:    ext = sh[7]  ? ((sh & 32'hFF)   | 32'hFFFF_FF00) : (sh & 32'hFF);
            3'd1:    ext = sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
            3'd4:    ext = sh & 32'hFF;
            3'd5:    ext = sh & 32'hFFFF;
            default: ext = t.rdata;
        endcase
        size = (t.f3[1:0] == 2'd0) ? 1 : (t.f3[1:0] == 2'd1) ? 2 : 4;
        mis  = t.valid && (t.wb == 2'd1) && (int'(t.alo) + size > 4);
        case (t.wb)
            2'd0:    wd = t.alu;
            2'd1:    wd = ext;
            2'd2:    wd = t.pc4;
            default: wd = 32'd0;
        endcase
        we = t.valid && (t.wb != 2'd3) && (t.rd != 5'd0) && !mis;
    endfunction

    // Checks the outputs of instance k produced by the posedge that sampled slot cyc-1.
    task automatic check(int k);
        txn_t t;
        txn_t c;
        bit   we;
        bit   mis;
        bit [31:0] wd;
        int   p;
        p = cyc - 1;
        t = get(p - lat(k));
        c = get(p);
        model(t, we, wd, mis);
        if (t.has_exp) begin
            we = t.ewe; wd = t.ewd; mis = t.emis;
        end
        chk("rf_we", k, 64'(we_o[k]), 64'(we));
        chk("misaligned", k, 64'(mis_o[k]), 64'(mis));
        if (t.valid) begin
            chk("rf_tid", k, 64'(tid_o[k]), 64'(t.tid));
            chk("rf_waddr", k, 64'(wa_o[k]), 64'(t.rd));
            if (!mis) chk("rf_wdata", k, 64'(wd_o[k]), 64'(wd));
        end
        if (c.clr) exp_cnt[k] = 64'd0;
        else if (t.valid) exp_cnt[k] = exp_cnt[k] + 64'd1;
        chk("instret", k, cnt_o[k], exp_cnt[k]);
    endtask

    task automatic step(txn_t t);
        txn_t d;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check(k);
        if (cyc > 4095) begin
            $display("FAIL history_overflow: cycle %0d, limit 4095", cyc);
            $fatal(1, "history overflow");
        end
        hist[cyc]      = t;
        i_valid        = t.valid;
        i_tid          = t.tid;
        i_rd           = t.rd;
        i_wb_sel       = t.wb;
        i_pc_plus4     = t.pc4;
        i_load_funct3  = t.f3;
        i_load_addr_lo = t.alo;
        i_instret_clr  = t.clr;
        for (int k = 0; k < 3; k++) begin
            d = get(cyc - lat(k));
            alu_d[k]  = d.alu;
            rdat_d[k] = d.rdata;
        end
        cyc++;
    endtask

    function automatic txn_t idle();
        txn_t t;
        t = '0;
        return t;
    endfunction

    function automatic txn_t alu_txn(int tid, int rd, logic [31:0] v);
        txn_t t;
        t = '0;
        t.valid = 1'b1; t.tid = 4'(tid); t.rd = 5'(rd); t.wb = 2'd0; t.alu = v;
        return t;
    endfunction

    task automatic chk_all_zero(string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_we"}, k, 64'(we_o[k]), 64'd0);
            chk({name, "_tid"}, k, 64'(tid_o[k]), 64'd0);
            chk({name, "_waddr"}, k, 64'(wa_o[k]), 64'd0);
            chk({name, "_wdata"}, k, 64'(wd_o[k]), 64'd0);
            chk({name, "_mis"}, k, 64'(mis_o[k]), 64'd0);
            chk({name, "_instret"}, k, cnt_o[k], 64'd0);
        end
    endtask

    vec_t vecs [14];
    txn_t t;
    logic [63:0] snap;

    initial begin
        for (int k = 0; k < 3; k++) begin
            alu_d[k] = '0; rdat_d[k] = '0; exp_cnt[k] = '0;
        end
        //          wb    f3    alo   rd     rdata          alu            we    wdata          mis
        vecs[0]  = '{2'd1, 3'd0, 2'd0, 5'd1,  32'h80FF_7F01, 32'h0,         1'b1, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'd1, 3'd0, 2'd3, 5'd2,  32'h80FF_7F01, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{2'd1, 3'd5, 2'd2, 5'd3,  32'h80FF_7F01, 32'h0,         1'b1, 32'h0000_80FF, 1'b0};
        vecs[3]  = '{2'd1, 3'd1, 2'd2, 5'd4,  32'h80FF_7F01, 32'h0,         1'b1, 32'hFFFF_80FF, 1'b0};
        vecs[4]  = '{2'd1, 3'd2, 2'd0, 5'd5,  32'h80FF_7F01, 32'h0,         1'b1, 32'h80FF_7F01, 1'b0};
        vecs[5]  = '{2'd1, 3'd4, 2'd1, 5'd6,  32'h80FF_7F01, 32'h0,         1'b1, 32'h0000_007F, 1'b0};
        vecs[6]  = '{2'd1, 3'd1, 2'd1, 5'd7,  32'h80FF_7F01, 32'h0,         1'b1, 32'hFFFF_FF7F, 1'b0};
        vecs[7]  = '{2'd1, 3'd0, 2'd2, 5'd8,  32'h80FF_7F01, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[8]  = '{2'd1, 3'd3, 2'd0, 5'd9,  32'h80FF_7F01, 32'h0,         1'b1, 32'h80FF_7F01, 1'b0};
        vecs[9]  = '{2'd0, 3'd0, 2'd0, 5'd0,  32'h0,         32'h0000_DEAD, 1'b0, 32'h0000_DEAD, 1'b0};
        vecs[10] = '{2'd3, 3'd0, 2'd0, 5'd7,  32'h0,         32'h1111_2222, 1'b0, 32'h0000_0000, 1'b0};
        vecs[11] = '{2'd1, 3'd2, 2'd2, 5'd9,  32'h80FF_7F01, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[12] = '{2'd1, 3'd5, 2'd3, 5'd10, 32'h80FF_7F01, 32'h0,         1'b0, 32'h0,         1'b1};
        vecs[13] = '{2'd2, 3'd0, 2'd0, 5'd11, 32'h0,         32'h5555_5555, 1'b1, 32'h0000_0104, 1'b0};

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First scenario on all three latencies: tid 3, rd 5, ALU result 0x12345678
        step(alu_txn(3, 5, 32'h1234_5678));
        for (int i = 0; i < 5; i++) step(idle());
        chk("first_instret", 1, cnt_o[1], 64'd1);

        // Table-driven load extension and suppression vectors
        snap = cnt_o[1];
        for (int i = 0; i < 14; i++) begin
            t = '0;
            t.valid = 1'b1; t.tid = 4'(i); t.rd = vecs[i].rd; t.wb = vecs[i].wb;
            t.pc4 = 32'h0000_0104; t.f3 = vecs[i].f3; t.alo = vecs[i].alo;
            t.alu = vecs[i].alu; t.rdata = vecs[i].rdata;
            t.has_exp = 1'b1; t.ewe = vecs[i].ewe; t.ewd = vecs[i].ewd; t.emis = vecs[i].emis;
            step(t);
        end
        for (int i = 0; i < 5; i++) step(idle());
        chk("table_instret_delta", 1, cnt_o[1] - snap, 64'd14);

        // Back-to-back: 16 threads with no bubbles
        snap = cnt_o[1];
        for (int i = 0; i < 16; i++) step(alu_txn(i, i, 32'(i * 32'h11)));
        for (int i = 0; i < 5; i++) step(idle());
        chk("b2b_instret_delta", 1, cnt_o[1] - snap, 64'd16);

        // Counter wrap from a forced value near the top
        @(negedge clk);
        force u_l0.o_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        force u_l1.o_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        force u_l3.o_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release u_l0.o_instret;
        release u_l1.o_instret;
        release u_l3.o_instret;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 3; i++) step(alu_txn(1, 1, 32'(i)));
        for (int i = 0; i < 5; i++) step(idle());
        chk("wrap_instret", 1, cnt_o[1], 64'd1);

        // Clear at the same cycle as a retirement on every latency
        for (int i = 0; i < 5; i++) begin
            t = alu_txn(2, 3, 32'hA0 + 32'(i));
            t.clr = (i == 3);
            step(t);
        end
        for (int i = 0; i < 5; i++) step(idle());

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            t = '0;
            t.valid = ($urandom_range(0, 3) != 0);
            t.tid   = 4'($urandom);
            t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            t.wb    = 2'($urandom);
            t.pc4   = $urandom;
            t.f3    = 3'($urandom);
            t.alo   = 2'($urandom);
            t.alu   = $urandom;
            t.rdata = $urandom;
            t.clr   = ($urandom_range(0, 40) == 0);
            step(t);
        end
        for (int i = 0; i < 5; i++) step(idle());

        // Reset while an instruction is in flight
        step(alu_txn(6, 12, 32'hCAFE_F00D));
        @(negedge clk);
        for (int k = 0; k < 3; k++) check(k);
        cyc++;
        rst_n = 1'b0;
        i_valid = 1'b0; i_instret_clr = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) exp_cnt[k] = 64'd0;
        for (int i = 0; i < 6; i++) step(idle());
        chk("post_reset_instret", 2, cnt_o[2], 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
